// File: rtl/write_back_stage.sv
// rtl/write_back_stage.sv - registered RV32 write-back stage with load formatting and EBREAK halt
//
// Purpose:
//   Takes one instruction per cycle from the MEM/DATA stage, selects the ALU
//   result or a formatted load value, and presents a registered write to the
//   register file one cycle after accept. EBREAK retires and then halts the
//   stage until reset.
//
// Optional feature:
//   WB_RETIRE_CNT_EN - when defined, retire_cnt_o counts retired instructions
//   (wraps at 2^CNT_W, freezes in HALT). When undefined, retire_cnt_o is 0.
//
// Ports:
//   clk_i, rst_i                 clock, asynchronous active-high reset
//   MD_valid_i / MD_ready_o      upstream handshake (ready depends on state only)
//   MD_instr_i, MD_pc_i          instruction word and its PC
//   MD_wen_i, MD_sel_reg_i       write enable, 1 = ALU result / 0 = load result
//   MD_valE_i, MD_valM_i         ALU result (load address), raw aligned memory word
//   W_valid_o, W_wen_o           retire pulse, register-file write enable
//   W_rd_o, W_data_o, W_pc_o     destination, write data, retiring PC
//   halt_o                       core halted by EBREAK
//   retire_cnt_o                 retired-instruction count

module write_back_stage #(
    parameter int XLEN        = 32,
    parameter int INSTR_WIDTH = 32,
    parameter int REG_ADDR_W  = 5,
    parameter int CNT_W       = 64
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   MD_valid_i,
    output logic                   MD_ready_o,
    input  logic [INSTR_WIDTH-1:0] MD_instr_i,
    input  logic [XLEN-1:0]        MD_pc_i,
    input  logic                   MD_wen_i,
    input  logic                   MD_sel_reg_i,
    input  logic [XLEN-1:0]        MD_valE_i,
    input  logic [XLEN-1:0]        MD_valM_i,
    output logic                   W_valid_o,
    output logic                   W_wen_o,
    output logic [REG_ADDR_W-1:0]  W_rd_o,
    output logic [XLEN-1:0]        W_data_o,
    output logic [XLEN-1:0]        W_pc_o,
    output logic                   halt_o,
    output logic [CNT_W-1:0]       retire_cnt_o
);

    localparam logic [INSTR_WIDTH-1:0] EBREAK_INSTR = INSTR_WIDTH'(32'h0010_0073);

    typedef enum logic {
        RUN  = 1'b0,
        HALT = 1'b1
    } state_t;

    state_t state;

    logic                  accept;
    logic                  is_ebreak;
    logic [REG_ADDR_W-1:0] rd;
    logic [2:0]            funct3;
    logic [1:0]            off;
    logic [7:0]            byte_sel;
    logic [15:0]           half_sel;
    logic [XLEN-1:0]       load_data;
    logic [XLEN-1:0]       wb_data;

    assign MD_ready_o = (state == RUN);
    assign accept     = MD_valid_i & MD_ready_o;
    assign is_ebreak  = (MD_instr_i == EBREAK_INSTR);
    assign rd         = MD_instr_i[7 +: REG_ADDR_W];
    assign funct3     = MD_instr_i[14:12];
    assign off        = MD_valE_i[1:0];

    // Little-endian lane select; halfword ignores off[0] (misaligned halves
    // are assumed to have been handled upstream).
    always_comb begin
        byte_sel = MD_valM_i[7:0];
        case (off)
            2'd0: byte_sel = MD_valM_i[7:0];
            2'd1: byte_sel = MD_valM_i[15:8];
            2'd2: byte_sel = MD_valM_i[23:16];
            2'd3: byte_sel = MD_valM_i[31:24];
            default: byte_sel = MD_valM_i[7:0];
        endcase
        half_sel = off[1] ? MD_valM_i[31:16] : MD_valM_i[15:0];
    end

    always_comb begin
        load_data = MD_valM_i;
        case (funct3)
            3'b000: load_data = {{(XLEN-8){byte_sel[7]}}, byte_sel};
            3'b001: load_data = {{(XLEN-16){half_sel[15]}}, half_sel};
            3'b010: load_data = MD_valM_i;
            3'b100: load_data = {{(XLEN-8){1'b0}}, byte_sel};
            3'b101: load_data = {{(XLEN-16){1'b0}}, half_sel};
            default: load_data = MD_valM_i;
        endcase
    end

    assign wb_data = MD_sel_reg_i ? MD_valE_i : load_data;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state     <= RUN;
            W_valid_o <= 1'b0;
            W_wen_o   <= 1'b0;
            W_rd_o    <= '0;
            W_data_o  <= '0;
            W_pc_o    <= '0;
            halt_o    <= 1'b0;
        end else begin
            // valid/wen are pulses; payload holds between accepts
            W_valid_o <= accept;
            W_wen_o   <= accept & MD_wen_i & (rd != '0) & ~is_ebreak;
            if (accept) begin
                W_rd_o   <= rd;
                W_data_o <= wb_data;
                W_pc_o   <= MD_pc_i;
            end
            case (state)
                RUN: begin
                    if (accept && is_ebreak) begin
                        state  <= HALT;
                        halt_o <= 1'b1;
                    end
                end
                HALT: begin
                    state  <= HALT;
                    halt_o <= 1'b1;
                end
                default: begin
                    state  <= RUN;
                    halt_o <= 1'b0;
                end
            endcase
        end
    end

`ifdef WB_RETIRE_CNT_EN
    // Counting on accept keeps the count in step with W_valid_o, so the
    // value is already updated on the retire cycle itself. No accepts occur
    // in HALT, so the count freezes there without extra logic.
    logic [CNT_W-1:0] retire_cnt;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            retire_cnt <= '0;
        end else if (accept) begin
            retire_cnt <= retire_cnt + 1'b1;
        end
    end

    assign retire_cnt_o = retire_cnt;
`else
    assign retire_cnt_o = '0;
`endif

endmodule

// File: tb/tb_write_back_stage.sv
// tb/tb_write_back_stage.sv - self-checking bench for write_back_stage

module tb_write_back_stage;

    localparam logic [31:0] EBREAK = 32'h0010_0073;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b1;
    logic        MD_valid_i = 1'b0;
    logic        MD_ready_o;
    logic [31:0] MD_instr_i = '0;
    logic [31:0] MD_pc_i = '0;
    logic        MD_wen_i = 1'b0;
    logic        MD_sel_reg_i = 1'b0;
    logic [31:0] MD_valE_i = '0;
    logic [31:0] MD_valM_i = '0;
    logic        W_valid_o;
    logic        W_wen_o;
    logic [4:0]  W_rd_o;
    logic [31:0] W_data_o;
    logic [31:0] W_pc_o;
    logic        halt_o;
    logic [3:0]  retire_cnt_o;

    write_back_stage #(.CNT_W(4)) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .MD_valid_i(MD_valid_i), .MD_ready_o(MD_ready_o),
        .MD_instr_i(MD_instr_i), .MD_pc_i(MD_pc_i),
        .MD_wen_i(MD_wen_i), .MD_sel_reg_i(MD_sel_reg_i),
        .MD_valE_i(MD_valE_i), .MD_valM_i(MD_valM_i),
        .W_valid_o(W_valid_o), .W_wen_o(W_wen_o), .W_rd_o(W_rd_o),
        .W_data_o(W_data_o), .W_pc_o(W_pc_o), .halt_o(halt_o),
        .retire_cnt_o(retire_cnt_o)
    );

    always #5 clk_i = ~clk_i;

    int tests = 0;
    int fails = 0;

    // reference model state
    bit          m_halted;
    bit          m_valid, m_wen;
    bit [4:0]    m_rd;
    bit [31:0]   m_data, m_pc;
    int unsigned m_cnt;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic bit [31:0] ref_load(input bit [2:0] f3, input bit [1:0] off, input bit [31:0] m);
        int unsigned b, h;
        b = (m >> (8 * off)) & 32'hFF;
        h = (m >> (16 * (off / 2))) & 32'hFFFF;
        case (f3)
            3'd0: return (b >= 128) ? b + 32'hFFFF_FF00 : b;
            3'd1: return (h >= 32768) ? h + 32'hFFFF_0000 : h;
            3'd4: return b;
            3'd5: return h;
            default: return m;
        endcase
    endfunction

    function automatic bit [31:0] mk_instr(input bit [4:0] rd, input bit [2:0] f3, input bit [6:0] opc);
        return {17'h0, f3, rd, opc};
    endfunction

    task automatic check_all(input string tag);
        bit [31:0] exp_cnt;
`ifdef WB_RETIRE_CNT_EN
        exp_cnt = m_cnt % 16;
`else
        exp_cnt = 0;
`endif
        check({tag, ".valid"}, {31'b0, W_valid_o}, {31'b0, m_valid});
        check({tag, ".wen"},   {31'b0, W_wen_o},   {31'b0, m_wen});
        check({tag, ".rd"},    {27'b0, W_rd_o},    {27'b0, m_rd});
        check({tag, ".data"},  W_data_o, m_data);
        check({tag, ".pc"},    W_pc_o, m_pc);
        check({tag, ".halt"},  {31'b0, halt_o},    {31'b0, m_halted});
        check({tag, ".ready"}, {31'b0, MD_ready_o}, {31'b0, !m_halted});
        check({tag, ".cnt"},   {28'b0, retire_cnt_o}, exp_cnt);
    endtask

    task automatic model_reset();
        m_halted = 0; m_valid = 0; m_wen = 0; m_rd = 0; m_data = 0; m_pc = 0; m_cnt = 0;
    endtask

    // Drives one cycle of upstream inputs, clocks, and checks outputs 1 ns after the edge.
    task automatic do_cycle(input string tag, input bit valid, input bit [31:0] instr,
                            input bit [31:0] pc, input bit wen, input bit sel,
                            input bit [31:0] vale, input bit [31:0] valm);
        bit acc;
        MD_valid_i = valid; MD_instr_i = instr; MD_pc_i = pc; MD_wen_i = wen;
        MD_sel_reg_i = sel; MD_valE_i = vale; MD_valM_i = valm;
        acc = valid && !m_halted;
        @(posedge clk_i);
        #1;
        m_valid = acc;
        m_wen   = acc && wen && (instr[11:7] != 0) && (instr != EBREAK);
        if (acc) begin
            m_rd   = instr[11:7];
            m_data = sel ? vale : ref_load(instr[14:12], vale[1:0], valm);
            m_pc   = pc;
            m_cnt++;
            if (instr == EBREAK) m_halted = 1;
        end
        check_all(tag);
    endtask

    task automatic apply_reset();
        rst_i = 1'b1;
        #1;
        model_reset();
        check_all("reset");
        @(negedge clk_i);
        rst_i = 1'b0;
    endtask

    initial begin
        bit [31:0] lv = 32'h80FF7F01;
        model_reset();

        // reset state
        #2;
        check_all("por");
        @(negedge clk_i);
        rst_i = 1'b0;
        #1;
        check_all("post_reset");

        // addi x1,x0,5 then idle
        do_cycle("addi", 1, 32'h0050_0093, 32'h8000_0000, 1, 1, 5, 0);
        check("addi.data_lit", W_data_o, 32'd5);
        do_cycle("idle", 0, 0, 0, 0, 0, 0, 0);

        // load formatting table
        do_cycle("lb2",  1, mk_instr(5'd3, 3'd0, 7'h03), 32'h100, 1, 0, 32'h1002, lv);
        check("lb2_lit", W_data_o, 32'hFFFF_FFFF);
        do_cycle("lbu3", 1, mk_instr(5'd4, 3'd4, 7'h03), 32'h104, 1, 0, 32'h1003, lv);
        check("lbu3_lit", W_data_o, 32'h0000_0080);
        do_cycle("lb1",  1, mk_instr(5'd5, 3'd0, 7'h03), 32'h108, 1, 0, 32'h1001, lv);
        check("lb1_lit", W_data_o, 32'h0000_007F);
        do_cycle("lh2",  1, mk_instr(5'd6, 3'd1, 7'h03), 32'h10C, 1, 0, 32'h1002, lv);
        check("lh2_lit", W_data_o, 32'hFFFF_80FF);
        do_cycle("lhu0", 1, mk_instr(5'd7, 3'd5, 7'h03), 32'h110, 1, 0, 32'h1000, lv);
        check("lhu0_lit", W_data_o, 32'h0000_7F01);
        do_cycle("lw",   1, mk_instr(5'd8, 3'd2, 7'h03), 32'h114, 1, 0, 32'h1003, lv);
        check("lw_lit", W_data_o, 32'h80FF_7F01);

        // x0 suppression
        do_cycle("x0", 1, mk_instr(5'd0, 3'd0, 7'h13), 32'h118, 1, 1, 32'h1234, 0);
        check("x0.wen_lit", {31'b0, W_wen_o}, 32'd0);

        // randomized traffic
        for (int i = 0; i < 60; i++) begin
            bit [31:0] ins;
            ins = $urandom;
            if (ins == EBREAK) ins = ins ^ 32'h1;
            do_cycle("rand", ($urandom_range(0, 3) != 0), ins, $urandom, $urandom_range(0, 1),
                     $urandom_range(0, 1), $urandom, $urandom);
        end

        // 17 back-to-back retires from reset: counter wraps to 1 when enabled
        @(negedge clk_i);
        apply_reset();
        for (int i = 0; i < 17; i++)
            do_cycle("b2b", 1, mk_instr(5'(i % 31 + 1), 3'd0, 7'h13), 32'h200 + 4 * i, 1, 1, i, 0);
`ifdef WB_RETIRE_CNT_EN
        check("wrap_lit", {28'b0, retire_cnt_o}, 32'd1);
`endif

        // EBREAK stream with valid held high
        do_cycle("pre_eb", 1, 32'h0050_0093, 32'h8000_000C, 1, 1, 5, 0);
        do_cycle("ebreak", 1, EBREAK, 32'h8000_0010, 1, 1, 32'hDEAD, 0);
        check("eb.pc_lit", W_pc_o, 32'h8000_0010);
        check("eb.wen_lit", {31'b0, W_wen_o}, 32'd0);
        for (int i = 0; i < 4; i++)
            do_cycle("halted", 1, 32'h0050_0093, 32'h8000_0014, 1, 1, 7, 0);
        check("halted.valid_lit", {31'b0, W_valid_o}, 32'd0);

        // async reset while W_valid_o is high
        @(negedge clk_i);
        apply_reset();
        do_cycle("pre_rst", 1, mk_instr(5'd9, 3'd0, 7'h13), 32'h300, 1, 1, 32'h55, 0);
        check("pre_rst.valid_lit", {31'b0, W_valid_o}, 32'd1);
        #2;
        rst_i = 1'b1;
        #1;
        model_reset();
        check_all("mid_rst");
        @(negedge clk_i);
        rst_i = 1'b0;
        #1;
        check_all("after_rst");
        do_cycle("resume", 1, mk_instr(5'd10, 3'd0, 7'h13), 32'h400, 1, 1, 32'h77, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/write_back_stage.md
Name: write_back_stage

Overview:
- Registered, parametrised write-back stage of the pipelined RV32 core. It sits between the MEM/DATA stage (MD_*) and the register-file write port (W_*).
- Selects the ALU result or the load data. Loads get byte/half extraction plus sign or zero extension.
- Handshakes with the upstream stage, suppresses x0 writes, and halts retirement on EBREAK.

Parameters:
- XLEN, 32, datapath width in bits.
- INSTR_WIDTH, 32, instruction width in bits.
- REG_ADDR_W, 5, register index width.
- CNT_W, 64, retire counter width (used only with the optional feature).

Ports:
- clk_i  input  1  core clock
- rst_i  input  1  reset; asynchronous, active-high
- MD_valid_i  input  1  upstream holds a valid instruction
- MD_ready_o  output  1  stage can accept an instruction
- MD_instr_i  input  INSTR_WIDTH  instruction; rd = [11:7], funct3 = [14:12]
- MD_pc_i  input  XLEN  instruction PC
- MD_wen_i  input  1  instruction writes rd
- MD_sel_reg_i  input  1  1 = write MD_valE_i, 0 = write load result
- MD_valE_i  input  XLEN  ALU result; for loads, the effective address
- MD_valM_i  input  XLEN  raw aligned memory word
- W_valid_o  output  1  one-cycle retire pulse
- W_wen_o  output  1  register-file write enable
- W_rd_o  output  REG_ADDR_W  destination register
- W_data_o  output  XLEN  write-back data
- W_pc_o  output  XLEN  PC of the retiring instruction
- halt_o  output  1  core halted by EBREAK
- retire_cnt_o  output  CNT_W  retired-instruction count (optional feature only)

Behaviour:
- Reset (async, rst_i=1): state RUN; W_valid_o, W_wen_o, W_rd_o, W_data_o, W_pc_o, halt_o and retire_cnt_o all 0. Reset asserted mid-operation discards any in-flight output immediately.
- Clock and reset apply to all state; there is no other clock domain.
- MD_ready_o = (state == RUN). It is combinational from state only, with no dependence on MD_valid_i.
- Accept = MD_valid_i & MD_ready_o, sampled on the rising clk_i edge.
- Latency: all W_* outputs are registered and appear exactly 1 cycle after accept.
  - W_valid_o is high for exactly one cycle per accepted instruction, and 0 on cycles with no accept.
  - W_wen_o is forced to 0 whenever W_valid_o is 0.
  - W_rd_o, W_data_o and W_pc_o hold their last values when there is no accept.
- W_wen_o = MD_wen_i & (rd != 0) & ~is_ebreak.
- Data select:
  - MD_sel_reg_i=1: W_data_o = MD_valE_i.
  - MD_sel_reg_i=0: load formatting, using off = MD_valE_i[1:0] and funct3:
    - 000 LB: byte at off, sign-extended to XLEN.
    - 001 LH: halfword at off[1] (off[0] ignored), sign-extended.
    - 010 LW: full word; off ignored.
    - 100 LBU: byte at off, zero-extended.
    - 101 LHU: halfword at off[1], zero-extended.
    - any other funct3: MD_valM_i unmodified.
- Byte lanes are little-endian: off=0 selects bits [7:0], off=3 selects bits [31:24].
- State machine RUN / HALT:
  - RUN -> HALT on accept of MD_instr_i == 32'h00100073 (EBREAK).
  - The EBREAK itself retires: W_valid_o=1, W_wen_o=0, W_pc_o = its PC.
  - halt_o=1 and MD_ready_o=0 from the cycle after the EBREAK accept.
  - HALT is exited only by reset. Instructions presented while in HALT are not accepted and produce no W_valid_o.
- Back-to-back accepts every cycle are supported at full throughput, with no bubbles.

Optional Feature:
- Macro WB_RETIRE_CNT_EN.
- Defined:
  - retire_cnt_o is a CNT_W-bit counter that increments by 1 on every W_valid_o cycle, including the EBREAK retire.
  - It wraps from 2^CNT_W-1 to 0 and resets to 0.
  - It freezes in HALT.
- Undefined: no counter register is built and retire_cnt_o is tied to 0.

Test Plan:
- Reset then ALU op: accept instr 0x00500093 (addi x1,x0,5), MD_sel_reg_i=1, MD_valE_i=5, MD_wen_i=1 -> next cycle W_valid_o=1, W_wen_o=1, W_rd_o=1, W_data_o=5; following idle cycle W_valid_o=0.
- Load extension with MD_valM_i=0x80FF7F01:
  - LB off=2 -> 0xFFFFFFFF
  - LBU off=3 -> 0x00000080
  - LB off=1 -> 0x0000007F
  - LH off=2 -> 0xFFFF80FF
  - LHU off=0 -> 0x00007F01
  - LW -> 0x80FF7F01
- x0 suppression: accept with rd=0, MD_wen_i=1 -> W_valid_o=1, W_wen_o=0.
- EBREAK: stream addi, EBREAK (PC 0x80000010), addi with MD_valid_i held high ->
  - EBREAK retires with W_pc_o=0x80000010 and W_wen_o=0.
  - halt_o=1 and MD_ready_o=0 thereafter.
  - The third instruction never produces W_valid_o.
- Async reset mid-stream: assert rst_i between clock edges while W_valid_o=1 -> all outputs 0 immediately; after release MD_ready_o=1 and state is RUN.
- WB_RETIRE_CNT_EN defined, CNT_W=4: retire 17 instructions back-to-back -> retire_cnt_o reads 1 after the 17th retire (wrap); counter stays constant while halted.
